// File: rtl/aes_decrypt_if.sv
// Request/response bundle for the AES-128 decryptor.
// The master side drives the ciphertext, key and request.
// The slave side (the core) returns the plaintext, busy and completion pulse.
interface aes_decrypt_if;
    logic [127:0] datain;
    logic [127:0] key;
    logic         in_valid;
    logic [127:0] dataout;
    logic         aes_busy;
    logic         valid_out;

    modport master (
        output datain, key, in_valid,
        input  dataout, aes_busy, valid_out
    );

    modport slave (
        input  datain, key, in_valid,
        output dataout, aes_busy, valid_out
    );
endinterface

// File: rtl/aes_decrypt.sv
// AES-128 decryptor (FIPS-197 InvCipher), iterative core.
// Operation: forward key expansion over N cycles, then 10 inverse rounds over N cycles,
// where N = 10 / ROUNDS_PER_CYCLE (legal values 1, 2, 5).
// Optional build macro AES_DEC_KEY_CACHE_EN: keep the last expanded key schedule and skip
// key expansion when the next request carries the same key.
module aes_decrypt #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input logic          clk,
    input logic          reset,
    aes_decrypt_if.slave bus
);
    localparam int unsigned N       = 10 / ROUNDS_PER_CYCLE;
    localparam logic [3:0]  R4      = 4'(ROUNDS_PER_CYCLE);
    localparam logic [3:0]  LastCnt = 4'(N - 1);

    typedef enum logic [1:0] {StIdle, StKeyExp, StDec} state_e;

    // ---------------------------------------------------------------- GF(2^8) helpers
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [7:0] rcon_at(input logic [3:0] i);
        logic [7:0] rc;
        unique case (i)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // One step of the forward key schedule; word 0 is [127:96].
    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte i of the block sits at [127-8i -: 8]; byte 4c+r is row r, column c.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127 - 32 * c -: 32];
            o[127 - 32 * c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
            };
        end
        return o;
    endfunction

    // ---------------------------------------------------------------- state
    state_e       fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] rk_q [11];          // rk_q[0] is the cipher key, rk_q[1..10] the schedule
    logic [127:0] data_q;
    logic [127:0] st_q;
    logic [127:0] dataout_q;
    logic         valid_q;
    logic         busy_q;

    logic         accept, hit, kexp_last, dec_done, cache_hit;
    logic [127:0] kexp_keys [ROUNDS_PER_CYCLE];
    logic [127:0] dec_out;

`ifdef AES_DEC_KEY_CACHE_EN
    logic cache_valid_q;

    // rk_q[0] always holds the key that the cached schedule was built from.
    assign cache_hit = cache_valid_q && (bus.key == rk_q[0]);

    // Cache is valid only once a full schedule has been built; any new expansion or reset
    // invalidates it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid_q <= 1'b0;
        end else if (accept && !hit) begin
            cache_valid_q <= 1'b0;
        end else if (kexp_last) begin
            cache_valid_q <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    assign bus.dataout   = dataout_q;
    assign bus.valid_out = valid_q;
    assign bus.aes_busy  = busy_q;

    // Key expansion chain: R consecutive round keys derived from the last stored one.
    always_comb begin : kexp_chain
        logic [127:0] k;
        logic [3:0]   idx;
        k = rk_q[cnt_q * R4];
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            idx          = cnt_q * R4 + 4'(j);
            k            = key_expand(k, rcon_at(idx));
            kexp_keys[j] = k;
        end
    end

    // Inverse round chain: R rounds per cycle, round 0 omits InvMixColumns.
    always_comb begin : dec_chain
        logic [127:0] s;
        logic [3:0]   r;
        s = st_q;
        r = 4'd0;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            r = 4'd9 - cnt_q * R4 - 4'(j);
            s = inv_sub_bytes(inv_shift_rows(s)) ^ rk_q[r];
            if (r != 4'd0) s = inv_mix_columns(s);
        end
        dec_out = s;
    end

    // FSM state and round counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q <= StIdle;
            cnt_q <= 4'd0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
        end
    end

    // Next-state logic and phase strobes.
    always_comb begin
        fsm_d     = fsm_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        hit       = 1'b0;
        kexp_last = 1'b0;
        dec_done  = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    cnt_d  = 4'd0;
                    if (cache_hit) begin
                        hit   = 1'b1;
                        fsm_d = StDec;
                    end else begin
                        fsm_d = StKeyExp;
                    end
                end
            end
            StKeyExp: begin
                if (cnt_q == LastCnt) begin
                    kexp_last = 1'b1;
                    fsm_d     = StDec;
                    cnt_d     = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDec: begin
                if (cnt_q == LastCnt) begin
                    dec_done = 1'b1;
                    fsm_d    = StIdle;
                    cnt_d    = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    // Round key file; contents are only meaningful while busy or behind a valid cache.
    always_ff @(posedge clk) begin
        if (accept) rk_q[0] <= bus.key;
        if (fsm_q == StKeyExp) begin
            for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
                rk_q[cnt_q * R4 + 4'(j) + 4'd1] <= kexp_keys[j];
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= '0;
            st_q      <= '0;
            dataout_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (accept) begin
                busy_q <= 1'b1;
                data_q <= bus.datain;
                if (hit) st_q <= bus.datain ^ rk_q[10];
            end
            // Initial AddRoundKey uses rk[10] straight out of the expansion chain.
            if (kexp_last) st_q <= data_q ^ kexp_keys[ROUNDS_PER_CYCLE - 1];
            if (fsm_q == StDec) st_q <= dec_out;
            if (dec_done) begin
                dataout_q <= dec_out;
                valid_q   <= 1'b1;
                busy_q    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_aes_decrypt.sv
// Directed known-answer bench for aes_decrypt at ROUNDS_PER_CYCLE = 1, 2 and 5.
// Honours AES_DEC_KEY_CACHE_EN when computing expected latencies.
module tb_aes_decrypt;
`ifdef AES_DEC_KEY_CACHE_EN
    localparam bit CacheEn = 1'b1;
`else
    localparam bit CacheEn = 1'b0;
`endif

    localparam logic [127:0] ZeroCt = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] GfsCt  = 128'h0336763e966d92595a567cc9ce537f5e;
    localparam logic [127:0] GfsPt  = 128'hf34481ec3cc627bacd5dc3fb08f273e6;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aes_decrypt_if bus0 ();
    aes_decrypt_if bus1 ();
    aes_decrypt_if bus2 ();

    aes_decrypt #(.ROUNDS_PER_CYCLE(1)) u_dut_r1 (.clk(clk), .reset(reset), .bus(bus0));
    aes_decrypt #(.ROUNDS_PER_CYCLE(2)) u_dut_r2 (.clk(clk), .reset(reset), .bus(bus1));
    aes_decrypt #(.ROUNDS_PER_CYCLE(5)) u_dut_r5 (.clk(clk), .reset(reset), .bus(bus2));

    logic [127:0] dout [3];
    logic         vout [3];
    logic         busy [3];
    assign dout[0] = bus0.dataout;
    assign dout[1] = bus1.dataout;
    assign dout[2] = bus2.dataout;
    assign vout[0] = bus0.valid_out;
    assign vout[1] = bus1.valid_out;
    assign vout[2] = bus2.valid_out;
    assign busy[0] = bus0.aes_busy;
    assign busy[1] = bus1.aes_busy;
    assign busy[2] = bus2.aes_busy;

    int           n_vec = 0;
    int           n_bad = 0;
    int           nrounds [3] = '{10, 5, 2};
    bit           cache_ok [3] = '{1'b0, 1'b0, 1'b0};
    logic [127:0] cache_key [3];
    vec_t         tbl [4];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [127:0] k, input logic [127:0] c,
                                input logic [127:0] p);
        vec_t v;
        v.name = n;
        v.key  = k;
        v.ct   = c;
        v.pt   = p;
        return v;
    endfunction

    function automatic int exp_lat(input int i, input logic [127:0] k);
        if (CacheEn && cache_ok[i] && cache_key[i] == k) return nrounds[i];
        return 2 * nrounds[i];
    endfunction

    // Apply one block to all three cores, then watch a bounded window for completions.
    task automatic run_all(input vec_t v);
        int           lat [3];
        int           pulses [3];
        int           el [3];
        logic [127:0] got [3];
        for (int i = 0; i < 3; i++) begin
            el[i]     = exp_lat(i, v.key);
            lat[i]    = -1;
            pulses[i] = 0;
            got[i]    = '0;
        end
        @(negedge clk);
        bus0.datain = v.ct; bus0.key = v.key; bus0.in_valid = 1'b1;
        bus1.datain = v.ct; bus1.key = v.key; bus1.in_valid = 1'b1;
        bus2.datain = v.ct; bus2.key = v.key; bus2.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Inputs wander after accept; the block in flight must not notice.
        bus0.in_valid = 1'b0; bus0.datain = ~v.ct; bus0.key = ~v.key;
        bus1.in_valid = 1'b0; bus1.datain = ~v.ct; bus1.key = ~v.key;
        bus2.in_valid = 1'b0; bus2.datain = ~v.ct; bus2.key = ~v.key;
        chk({v.name, " busy"}, busy[0], 1'b1);
        for (int cyc = 0; cyc < 24; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (vout[i]) begin
                    pulses[i]++;
                    if (lat[i] < 0) begin
                        lat[i] = cyc;
                        got[i] = dout[i];
                    end
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s latency n=%0d", v.name, nrounds[i]), 128'(lat[i]), 128'(el[i]));
            chk($sformatf("%s data n=%0d", v.name, nrounds[i]), got[i], v.pt);
            chk($sformatf("%s pulses n=%0d", v.name, nrounds[i]), 128'(pulses[i]), 128'(1));
            cache_ok[i]  = 1'b1;
            cache_key[i] = v.key;
        end
    endtask

    // in_valid held high with datain toggling every cycle on the R=1 core.
    task automatic b2b_test();
        logic [127:0] sent_pt [128];
        logic [127:0] k0;
        int           accept_e, exp_e, blocks;
        k0       = '0;
        accept_e = 0;
        blocks   = 0;
        exp_e    = exp_lat(0, k0);
        @(negedge clk);
        bus0.key      = k0;
        bus0.in_valid = 1'b1;
        for (int e = 0; e < 100 && blocks < 3; e++) begin
            bus0.datain = (e % 2 == 0) ? ZeroCt : GfsCt;
            sent_pt[e]  = (e % 2 == 0) ? 128'h0 : GfsPt;
            @(posedge clk);
            @(negedge clk);
            if (e == exp_e) begin
                chk($sformatf("b2b valid %0d", blocks), vout[0], 1'b1);
                chk($sformatf("b2b data %0d", blocks), dout[0], sent_pt[accept_e]);
                cache_ok[0]  = 1'b1;
                cache_key[0] = k0;
                blocks++;
                accept_e = e + 1;
                exp_e    = accept_e + exp_lat(0, k0);
            end else if (vout[0]) begin
                chk($sformatf("b2b stray valid at %0d", e), vout[0], 1'b0);
            end
        end
        bus0.in_valid = 1'b0;
        chk("b2b blocks", 128'(blocks), 128'(3));
        repeat (24) @(negedge clk);
    endtask

    task automatic abort_test();
        int pulses;
        pulses = 0;
        @(negedge clk);
        bus0.datain = tbl[0].ct; bus0.key = tbl[0].key; bus0.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", busy[0], 1'b0);
        chk("abort valid", vout[0], 1'b0);
        chk("abort dataout", dout[0], 128'h0);
        for (int i = 0; i < 3; i++) cache_ok[i] = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (vout[0]) pulses++;
        end
        chk("abort no valid_out", 128'(pulses), 128'(0));
    endtask

    initial begin
        tbl[0] = mk("fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);
        tbl[1] = mk("fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734);
        tbl[2] = mk("zero", 128'h0, ZeroCt, 128'h0);
        tbl[3] = mk("gfsbox", 128'h0, GfsCt, GfsPt);

        bus0.in_valid = 1'b0; bus0.datain = '0; bus0.key = '0;
        bus1.in_valid = 1'b0; bus1.datain = '0; bus1.key = '0;
        bus2.in_valid = 1'b0; bus2.datain = '0; bus2.key = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset dataout", dout[0], 128'h0);
        chk("reset valid_out", vout[0], 1'b0);
        chk("reset busy", busy[0], 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) run_all(tbl[i]);

        b2b_test();
        abort_test();

        // Cache sequence: same key twice, then a new key.
        run_all(tbl[0]);
        run_all(tbl[0]);
        run_all(tbl[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
